npc_ifu_prefetch: RTL

- Parametrised next-generation instruction fetch unit for the npc core.
- Replaces the combinational fetch with a decoupled fetch pipeline.
- Issues in-order requests to instruction memory over a valid/ready handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Delivers instructions to the decode stage over valid/ready. Handles jump/branch redirect by flushing buffered and in-flight fetches.

---
 rtl/npc_ifu_prefetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/npc_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : npc_ifu_prefetch
// Description : Decoupled instruction prefetcher with credit-limited
//               in-order fetch, PC-tagged FIFO and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_ifu_prefetch #(
  parameter int          XLEN     = 64,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam int              PW         = $clog2(DEPTH);
  localparam logic [XLEN-1:0] C_RESET_PC = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] C_PC_STEP  = XLEN'(4);
  localparam logic [CW:0]     C_DEPTH    = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   C_PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_tag_pc     [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_tag_rd;
  logic [PW-1:0]   r_tag_wr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW:0]     w_credit_used;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic [CW-1:0]   w_out_after_rsp;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  always_comb begin
    w_credit_used   = {1'b0, r_count} + {1'b0, r_outstanding};
    imem_req_valid  = !rst && !redirect_valid && (w_credit_used < C_DEPTH);
    imem_req_addr   = rst ? C_RESET_PC : r_fetch_pc;
    out_valid       = !rst && (r_count != '0);
    out_instr       = r_fifo_instr[r_rd_ptr];
    out_pc          = r_fifo_pc[r_rd_ptr];
    w_req_fire      = imem_req_valid && imem_req_ready;
    w_rsp_keep      = imem_rsp_valid && (r_drop_cnt == '0);
    w_pop           = out_valid && out_ready;
    w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);
  end

  // Control state; a redirect makes every in-flight request stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= C_RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= w_out_after_rsp;
      r_drop_cnt    <= w_out_after_rsp;
      if (imem_rsp_valid) begin
        r_tag_rd <= r_tag_rd + C_PTR_ONE;
      end
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + C_PC_STEP;
        r_tag_wr   <= r_tag_wr + C_PTR_ONE;
      end
      r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
      if (imem_rsp_valid) begin
        r_tag_rd <= r_tag_rd + C_PTR_ONE;
      end
      if (imem_rsp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - C_CNT_ONE;
      end
      if (w_rsp_keep) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= r_count + CW'(w_rsp_keep) - CW'(w_pop);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end
    if (!rst && !redirect_valid && w_rsp_keep) begin
      r_fifo_pc[r_wr_ptr]    <= r_tag_pc[r_tag_rd];
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire
